// File: rtl/spmv_row_collector_if.sv
// spmv_row_collector_if: row-event input bus and result stream of the SpMV row collector
interface spmv_row_collector_if #(
  parameter int ROW_W = 11
);
  logic in_valid;
  logic in_zeros;
  logic [63:0] in_data1;
  logic [63:0] in_data2;
  logic out_valid;
  logic out_ready;
  logic [ROW_W-1:0] out_row;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic out_sat;
  modport master (
    output in_valid, in_zeros, in_data1, in_data2, out_ready,
    input out_valid, out_row, out_data1, out_data2, out_sat
  );
  modport slave (
    input in_valid, in_zeros, in_data1, in_data2, out_ready,
    output out_valid, out_row, out_data1, out_data2, out_sat
  );
endinterface

// File: rtl/spmv_row_collector.sv
// spmv_row_collector: numbers row events, saturates both lanes to 32 bits and streams them out through a FIFO
module spmv_row_collector #(
  parameter int NUM_ROWS = 1120,
  parameter int ROW_W = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAC_SHIFT = 0
) (
  input logic clk,
  input logic rst,
  input logic start,
  spmv_row_collector_if.slave bus,
  output logic overflow,
  output logic busy,
  output logic done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ROW_W + 65;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ROW_W-1:0] row_cnt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] cnt, cnt_n;
  logic ev, pop, push;
  logic [32:0] l1, l2;
  logic [EW-1:0] entry;
  function automatic logic [32:0] clamp(input logic [63:0] d);
    logic signed [63:0] s;
    s = $signed(d) >>> FRAC_SHIFT;
    return s > 64'sh7FFFFFFF ? {1'b1, 32'h7FFFFFFF} :
           s < -64'sh80000000 ? {1'b1, 32'h80000000} : {1'b0, s[31:0]};
  endfunction
  assign ev = state == COLLECT && (bus.in_valid || bus.in_zeros);
  assign l1 = bus.in_valid ? clamp(bus.in_data1) : '0;
  assign l2 = bus.in_valid ? clamp(bus.in_data2) : '0;
  assign entry = {row_cnt, l1[31:0], l2[31:0], l1[32] | l2[32]};
  assign pop = bus.out_valid && bus.out_ready;
  assign push = ev && (cnt != FULL || pop);
  assign cnt_n = cnt + (AW + 1)'(push) - (AW + 1)'(pop);
  assign bus.out_valid = cnt != '0;
  // when empty, show the slot just popped so the head holds its last value
  assign {bus.out_row, bus.out_data1, bus.out_data2, bus.out_sat} = mem[cnt == '0 ? rd_ptr - 1'b1 : rd_ptr];
  assign busy = state == COLLECT || state == DRAIN;
  assign done = state == DONE;
  // next state; DRAIN ends on the cycle the last entry leaves so done follows the final pop directly
  always_comb begin
    state_n = state == IDLE ? (start ? COLLECT : IDLE) :
              state == COLLECT ? (ev && row_cnt == LAST ? DRAIN : COLLECT) :
              state == DRAIN ? (cnt_n == '0 ? DONE : DRAIN) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // row counter, overflow flag and FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt <= '0;
      overflow <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      mem <= '{default: '0};
    end else begin
      if (state == IDLE && start) begin
        row_cnt <= '0;
        overflow <= 1'b0;
      end
      if (ev) row_cnt <= row_cnt + 1'b1;
      if (ev && !push) overflow <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_spmv_row_collector.sv
// tb_spmv_row_collector: queue-based model checked every cycle plus directed literal checks
module tb_spmv_row_collector;
  localparam int NR = 10;
  localparam int RW = 4;
  localparam int DEPTH = 8;
  typedef struct {
    int unsigned row;
    logic [31:0] d1;
    logic [31:0] d2;
    logic sat;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic start1 = 0;
  logic overflow, busy, done, overflow1, busy1, done1;
  int passed = 0;
  int total = 0;
  ent_t mq[$];
  ent_t got[$];
  ent_t e, g;
  int phase = 0;
  int rows = 0;
  bit movf = 0;
  bit mpop, room, mev;
  int cyc = 0;
  int last_pop = 0;
  int done_cyc = 0;
  int b;
  spmv_row_collector_if #(.ROW_W(RW)) bus ();
  spmv_row_collector_if #(.ROW_W(RW)) bus1 ();
  spmv_row_collector #(.NUM_ROWS(NR), .ROW_W(RW), .FIFO_DEPTH(DEPTH), .FRAC_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .overflow(overflow), .busy(busy), .done(done)
  );
  spmv_row_collector #(.NUM_ROWS(4), .ROW_W(RW), .FIFO_DEPTH(DEPTH), .FRAC_SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .overflow(overflow1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    total++;
    if (got_v === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h", name, got_v, exp_v);
  endtask
  function automatic logic [32:0] sat32(input logic [63:0] d, input int fs);
    longint s;
    s = $signed(d) >>> fs;
    if (s > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (s < -64'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, s[31:0]};
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      mq.delete();
      phase = 0;
      rows = 0;
      movf = 0;
    end
    check("out_valid", bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_row", bus.out_row, mq[0].row);
      check("out_data1", bus.out_data1, mq[0].d1);
      check("out_data2", bus.out_data2, mq[0].d2);
      check("out_sat", bus.out_sat, mq[0].sat);
    end
    check("busy", busy, phase == 1 || phase == 2);
    check("done", done, phase == 3);
    check("overflow", overflow, movf);
    if (rst) begin
      mpop = mq.size() != 0 && bus.out_ready;
      room = mq.size() < DEPTH || mpop;
      mev = phase == 1 && (bus.in_valid || bus.in_zeros);
      if (bus.out_valid && bus.out_ready) begin
        g.row = bus.out_row;
        g.d1 = bus.out_data1;
        g.d2 = bus.out_data2;
        g.sat = bus.out_sat;
        got.push_back(g);
        last_pop = cyc;
      end
      if (done) done_cyc = cyc;
      if (mpop) void'(mq.pop_front());
      if (phase == 0) begin
        if (start) begin
          phase = 1;
          rows = 0;
          movf = 0;
        end
      end else if (phase == 1) begin
        if (mev) begin
          e.row = rows;
          e.d1 = bus.in_valid ? sat32(bus.in_data1, 0) : 0;
          e.d2 = bus.in_valid ? sat32(bus.in_data2, 0) : 0;
          e.sat = bus.in_valid && (sat32(bus.in_data1, 0) >> 32 || sat32(bus.in_data2, 0) >> 32);
          if (room) mq.push_back(e);
          else movf = 1;
          if (rows == NR - 1) phase = 2;
          rows++;
        end
      end else if (phase == 2) begin
        if (mq.size() == 0) phase = 3;
      end else phase = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic drive(input bit v, input bit z, input logic [63:0] a, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_zeros = z;
    bus.in_data1 = a;
    bus.in_data2 = d;
    tick();
  endtask
  task automatic quiet();
    bus.in_valid = 0;
    bus.in_zeros = 0;
  endtask
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      seen = done;
      if (!seen) tick();
    end
    check(name, seen, 1);
    if (seen) check({name, "_busy"}, busy, 0);
    tick();
  endtask
  initial begin
    int d1t[10] = '{5, 10, -3, 0, 7, 100, -100, 1, 2, 3};
    bit seen1;
    quiet();
    bus.in_data1 = 0;
    bus.in_data2 = 0;
    bus.out_ready = 0;
    bus1.in_valid = 0;
    bus1.in_zeros = 0;
    bus1.in_data1 = 0;
    bus1.in_data2 = 0;
    bus1.out_ready = 0;
    #2 rst = 0;
    repeat (3) tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_row", bus.out_row, 0);
    check("rst_d1", bus.out_data1, 0);
    check("rst_d2", bus.out_data2, 0);
    check("rst_sat", bus.out_sat, 0);
    rst = 1;
    tick();
    b = got.size();
    bus.out_ready = 1;
    pulse_start();
    for (int i = 0; i < NR; i++) drive(1, 0, longint'(d1t[i]), 1);
    quiet();
    wait_done("t1_done");
    check("t1_pops", got.size() - b, 10);
    check("t1_d1_r0", got[b].d1, 5);
    check("t1_d1_r1", got[b + 1].d1, 10);
    check("t1_d1_r2", got[b + 2].d1, 32'hFFFFFFFD);
    check("t1_d1_r3", got[b + 3].d1, 0);
    check("t1_d2_r2", got[b + 2].d2, 1);
    check("t1_row9", got[b + 9].row, 9);
    check("t1_done_lat", done_cyc - last_pop, 1);
    bus1.out_ready = 1;
    start1 = 1;
    tick();
    start1 = 0;
    bus1.in_valid = 1;
    bus1.in_data1 = 64'h100;
    bus1.in_data2 = 64'hFFFF_FFFF_FFFF_FF00;
    tick();
    check("fs4_valid", bus1.out_valid, 1);
    check("fs4_row0", bus1.out_row, 0);
    check("fs4_d1", bus1.out_data1, 32'h10);
    check("fs4_d2", bus1.out_data2, 32'hFFFFFFF0);
    check("fs4_sat0", bus1.out_sat, 0);
    bus1.in_data1 = 64'h10_0000_0000;
    bus1.in_data2 = 64'h7_FFFF_FFF0;
    tick();
    check("fs4_row1", bus1.out_row, 1);
    check("fs4_clamp", bus1.out_data1, 32'h7FFFFFFF);
    check("fs4_edge", bus1.out_data2, 32'h7FFFFFFF);
    check("fs4_sat1", bus1.out_sat, 1);
    bus1.in_valid = 0;
    bus1.in_zeros = 1;
    repeat (2) tick();
    bus1.in_zeros = 0;
    seen1 = 0;
    for (int i = 0; i < 50 && !seen1; i++) begin
      seen1 = done1;
      if (!seen1) tick();
    end
    check("fs4_done", seen1, 1);
    tick();
    b = got.size();
    pulse_start();
    drive(1, 0, 11, 21);
    drive(0, 1, 99, 99);
    drive(1, 1, -64'sd7, 33);
    drive(1, 0, 4, 5);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0);
    quiet();
    wait_done("t2_done");
    check("t2_pops", got.size() - b, 10);
    check("t2_zero_d1", got[b + 1].d1, 0);
    check("t2_zero_d2", got[b + 1].d2, 0);
    check("t2_both_row", got[b + 2].row, 2);
    check("t2_both_d1", got[b + 2].d1, 32'hFFFFFFF9);
    check("t2_both_d2", got[b + 2].d2, 33);
    check("t2_row3", got[b + 3].row, 3);
    b = got.size();
    pulse_start();
    drive(1, 0, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0000);
    drive(1, 0, 64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    drive(1, 0, 64'h8000_0000, 64'hFFFF_FFFF_7FFF_FFFF);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 0);
    quiet();
    wait_done("t3_done");
    check("t3_hi", got[b].d1, 32'h7FFFFFFF);
    check("t3_lo", got[b].d2, 32'h80000000);
    check("t3_sat", got[b].sat, 1);
    check("t3_max_d1", got[b + 1].d1, 32'h7FFFFFFF);
    check("t3_min_d2", got[b + 1].d2, 32'h80000000);
    check("t3_nosat", got[b + 1].sat, 0);
    check("t3_justover", got[b + 2].sat, 1);
    b = got.size();
    bus.out_ready = 0;
    pulse_start();
    for (int i = 0; i < NR; i++) drive(1, 0, 3 * i, i);
    quiet();
    tick();
    check("t4_ovf", overflow, 1);
    check("t4_busy", busy, 1);
    check("t4_head", bus.out_row, 0);
    repeat (5) tick();
    check("t4_hold", busy, 1);
    bus.out_ready = 1;
    wait_done("t4_done");
    check("t4_pops", got.size() - b, 8);
    check("t4_row7", got[b + 7].row, 7);
    check("t4_d1_7", got[b + 7].d1, 21);
    check("t4_sticky", overflow, 1);
    b = got.size();
    bus.out_ready = 0;
    pulse_start();
    check("t5_clear", overflow, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, i, 0);
    bus.out_ready = 1;
    drive(1, 0, 8, 0);
    bus.out_ready = 0;
    check("t5_accept", overflow, 0);
    drive(1, 0, 9, 0);
    quiet();
    tick();
    check("t5_still_full", overflow, 1);
    bus.out_ready = 1;
    wait_done("t5_done");
    check("t5_pops", got.size() - b, 9);
    check("t5_first", got[b].row, 0);
    check("t5_last", got[b + 8].row, 8);
    check("t5_last_d1", got[b + 8].d1, 8);
    b = got.size();
    pulse_start();
    for (int i = 0; i < 3; i++) drive(1, 0, i, 0);
    quiet();
    start = 1;
    tick();
    start = 0;
    for (int i = 3; i < NR; i++) drive(1, 0, i, 0);
    quiet();
    wait_done("t6_done");
    check("t6_pops", got.size() - b, 10);
    check("t6_row3", got[b + 3].row, 3);
    check("t6_row9", got[b + 9].row, 9);
    pulse_start();
    drive(1, 0, 1, 1);
    drive(1, 0, 2, 2);
    quiet();
    rst = 0;
    #1;
    check("t7_valid", bus.out_valid, 0);
    check("t7_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t7_nodone", done, 0);
    end
    rst = 1;
    repeat (3) begin
      tick();
      check("t7_idle_done", done, 0);
    end
    check("t7_idle_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/spmv_row_collector.md
Name: spmv_row_collector

Overview:
Downstream stage of the CSR sparse-matrix x dense-vector multiplier. The multiplier raises valid once per completed row and raises zeros once per empty row. This block assigns each event a row index and converts the two 64-bit lane accumulators to saturated 32-bit results. It buffers the results in a small FIFO and hands them to the result-writeback/host interface with a valid/ready handshake, then signals end of pass.

Parameters:
NUM_ROWS, 1120, rows per pass (matrix dimension)
ROW_W, 11, width of row index (must satisfy 2^ROW_W >= NUM_ROWS)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2)
FRAC_SHIFT, 0, arithmetic right shift applied to each 64-bit lane before saturation (0..32)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a new pass (honoured only in IDLE)
in_valid  in  1  multiplier row-complete strobe
in_zeros  in  1  multiplier empty-row strobe
in_data1  in  64  lane-1 accumulator, signed, sampled when in_valid=1
in_data2  in  64  lane-2 accumulator, signed, sampled when in_valid=1
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_row  out  ROW_W  row index of head entry
out_data1  out  32  lane-1 result, signed, saturated
out_data2  out  32  lane-2 result, signed, saturated
out_sat  out  1  head entry had at least one lane clamped
overflow  out  1  sticky; a row was dropped because the FIFO was full
busy  out  1  high in COLLECT and DRAIN
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Async reset (rst=0): state=IDLE; row_cnt=0; FIFO empty; all outputs 0.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE: in_valid/in_zeros ignored. start=1 -> COLLECT; row_cnt<=0; overflow<=0.
- COLLECT: each cycle with (in_valid | in_zeros) is one row event.
  - Entry pushed = {row_cnt, lane1, lane2, sat}.
  - in_valid=1: lane = clamp(in_data >>> FRAC_SHIFT).
  - in_zeros=1 and in_valid=0: lane1 = lane2 = 0, sat = 0.
  - in_valid and in_zeros both 1: treated as in_valid alone; one row only.
- row_cnt increments on every row event, whether or not the entry was pushed.
- When an event occurs with row_cnt == NUM_ROWS-1 -> DRAIN.
- DRAIN: input strobes ignored. When the FIFO is empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in COLLECT and DRAIN; 0 in IDLE and DONE.
- start is ignored outside IDLE. A start arriving in the DONE cycle is ignored.
- Saturation (per lane):
  - Signed 64-bit arithmetic shift right by FRAC_SHIFT.
  - Values > 2^31-1 become 0x7FFFFFFF; values < -2^31 become 0x80000000; sat=1 if either lane clamps.
- FIFO behaviour:
  - First-word-fall-through with a registered head.
  - An event at cycle n into an empty FIFO gives out_valid=1 at cycle n+1.
  - Pop when out_valid & out_ready.
  - Push when full: accepted if a pop happens in the same cycle. Otherwise the entry is dropped and overflow<=1 (sticky until the next accepted start).
  - Push and pop together with the FIFO at neither full nor empty leave the count unchanged.
- Outputs while out_valid=0: out_row/out_data*/out_sat hold their last values. The consumer must not sample them.
- Reset mid-pass: all state lost, FIFO flushed, no done pulse.

Test Plan:
- Reset then start, NUM_ROWS=4, out_ready=1; 4 in_valid pulses with data1=5, 10, -3, 0 and data2=1 -> out rows 0..3 with data1=5, 10, -3 (0xFFFFFFFD), 0; done pulses one cycle after the last pop; busy falls with it.
- Mixed events, NUM_ROWS=4: valid (row 0), zeros (row 1), valid+zeros together (row 2), valid (row 3) -> rows 0..3 emitted; row 1 data1=data2=0; row 2 carries in_data; exactly 4 pops.
- Saturation, FRAC_SHIFT=0: data1=0x0000_0001_0000_0000, data2=-0x0000_0001_0000_0000 -> out_data1=0x7FFFFFFF, out_data2=0x80000000, out_sat=1. With FRAC_SHIFT=4 and data1=0x100 -> out_data1=0x10, out_sat=0.
- Backpressure, FIFO_DEPTH=8, NUM_ROWS=10: out_ready=0 during 10 back-to-back events -> rows 0..7 kept, overflow=1, state stays DRAIN. Then out_ready=1 -> 8 pops with rows 0..7, then done.
- Full with simultaneous pop: fill 8 entries, then assert out_ready=1 and in_valid=1 in the same cycle -> entry accepted, overflow stays 0, count stays 8.
- Reset and start corner cases: rst low after 2 of 4 rows -> out_valid=0 immediately, no done pulse. start issued during COLLECT is ignored (row_cnt continues from its current value).
